// File: rtl/byte_serial_logic_unit_pkg.sv
// Shared constants for the ALU logic blocks: logic op encodings and the
// state encoding of the byte-serial logic unit FSM.
package byte_serial_logic_unit_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/byte_serial_logic_unit_slice.sv
// Combinational 8-bit logic slice built from gate primitives; the op select
// picks one of the four per-bit gate outputs.
module byte_logic_slice
    import byte_serial_logic_unit_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] z
);

    logic [7:0] and_w;
    logic [7:0] or_w;
    logic [7:0] xor_w;
    logic [7:0] nor_w;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        and g_and (and_w[i], a[i], b[i]);
        or  g_or  (or_w[i],  a[i], b[i]);
        xor g_xor (xor_w[i], a[i], b[i]);
        nor g_nor (nor_w[i], a[i], b[i]);
    end

    always_comb begin
        z = and_w;
        case (op)
            LOGIC_AND: z = and_w;
            LOGIC_OR:  z = or_w;
            LOGIC_XOR: z = xor_w;
            LOGIC_NOR: z = nor_w;
            default:   z = and_w;
        endcase
    end

endmodule

// File: rtl/byte_serial_logic_unit.sv
// Multi-cycle bitwise logic unit: operands are latched on accept and one byte
// of the result is produced per cycle through a single shared 8-bit slice.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for an operation
// RUN     | one result byte written per cycle, idx counts bytes
// DONE    | out_valid=1, result/zero held until out_ready
module byte_serial_logic_unit
    import byte_serial_logic_unit_pkg::*;
#(
    parameter  int WIDTH  = 32,
    localparam int NBYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
        $error("byte_serial_logic_unit: WIDTH must be a non-zero multiple of 8");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [7:0]         slice_a;
    logic [7:0]         slice_b;
    logic [7:0]         slice_z;
    logic [WIDTH-1:0]   result_upd;

    assign slice_a = a_q[8*int'(idx_q) +: 8];
    assign slice_b = b_q[8*int'(idx_q) +: 8];

    byte_logic_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .op (op_q),
        .z  (slice_z)
    );

    always_comb begin
        result_upd = result_q;
        result_upd[8*int'(idx_q) +: 8] = slice_z;

        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    result_d = '0;
                    idx_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d = result_upd;
                if (idx_q == IDX_W'(NBYTES - 1)) begin
                    // zero sees the full result including the byte being written now
                    idx_d       = '0;
                    zero_d      = (result_upd == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= LOGIC_AND;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_byte_serial_logic_unit.sv
// Scoreboard bench for byte_serial_logic_unit: directed cases plus random ops,
// expected results from a plain bitwise model, checked by a separate monitor.
module tb_byte_serial_logic_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    byte_serial_logic_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] r;
        logic        z;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ready_mode = 2;
    logic ov_prev  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at t=%0t", name, $time);
    endtask

    // Monitor: latency on rising out_valid, result/zero on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) timeout("unexpected_out_valid");
                else chk("latency", 64'(cyc), 64'(sb[0].acc + 4));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_result");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.r));
                    chk("zero", 64'(zero), 64'(e.z));
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int acc);
        int   n;
        exp_t e;
        n   = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                op = o; a = x; b = y; in_valid = 1'b1;
                break;
            end
            in_valid = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            n++;
            if (n > 200) begin
                timeout("accept");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
        e.r = model(o, x, y);
        e.z = (e.r == 32'h0);
        e.acc = acc;
        sb.push_back(e);
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_ov(input logic level, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== level) begin
            n++;
            if (n > 100) begin
                timeout(name);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                timeout("drain");
                return;
            end
        end
    endtask

    initial begin
        int acc1, acc2;
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b0;
        #23;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        ready_mode = 1;
        issue(2'b10, 32'hFF00_AA55, 32'h0F0F_F0F0, acc1);
        drain();
        issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0000, acc1);
        drain();
        issue(2'b00, 32'h1234_5678, 32'h0000_FFFF, acc1);
        drain();

        // Backpressure: result must sit still while out_ready is low
        ready_mode = 2;
        issue(2'b01, 32'h8000_0001, 32'h0000_0100, acc1);
        wait_ov(1'b1, "bp_out_valid");
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'h8000_0101);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        ready_mode = 1;
        wait_ov(1'b0, "bp_release");
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Operand isolation: garbage with in_valid during RUN/DONE
        issue(2'b10, 32'h0000_0001, 32'h0000_0000, acc1);
        a = 32'hFFFF_FFFF; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("iso_in_ready", 64'(in_ready), 64'd0);
        end
        wait_ov(1'b1, "iso_out_valid");
        chk("iso_result", 64'(result), 64'h0000_0001);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of RUN drops the pending op
        issue(2'b00, 32'hDEAD_BEEF, 32'hFFFF_0000, acc1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(result), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        issue(2'b00, 32'hCAFE_F00D, 32'h0F0F_0F0F, acc1);
        drain();

        // Back-to-back with out_ready tied high
        issue(2'b01, 32'h0000_00F0, 32'h0F00_0000, acc1);
        issue(2'b11, 32'h0000_0000, 32'hFFFF_FFFF, acc2);
        chk("b2b_spacing", 64'(acc2 - acc1), 64'd6);
        drain();

        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            logic [1:0]  o;
            x = $urandom;
            y = $urandom;
            o = 2'($urandom_range(0, 3));
            if (i % 8 == 3) y = x;
            if (i % 8 == 5) y = ~x;
            issue(o, x, y, acc1);
        end
        ready_mode = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_serial_logic_unit.md
Name: byte_serial_logic_unit

Overview:
- Multi-cycle bitwise logic unit for the MIPS32 ALU: AND, OR, XOR and NOR on two WIDTH-bit operands.
- Processes one byte per cycle through a single 8-bit logic slice, so the 8-bit gate-level slices are reused instead of replicated 4x.
- Sits between decode/operand fetch (upstream, valid/ready) and the result/writeback mux (downstream, valid/ready).
- Also produces a zero flag for branch compare use.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8.
- NBYTES, WIDTH/8, number of byte iterations. Derived; not overridden independently.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands and op are valid
- in_ready  output  1  unit can accept a new operation
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result is valid
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  logic result
- zero  output  1  high when result == 0

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, byte index=0, result=0, zero=0, out_valid=0. in_ready=1 once out of reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge, register a, b and op into internal operand registers, clear result to 0, set idx=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice computes byte idx from the registered operands and registered op.
  - At the edge, that byte is written into result[8*idx +: 8] and idx increments.
  - When idx==NBYTES-1 at an edge, write the final byte, compute zero from the full new result, set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1; result and zero are held stable.
  - On out_ready at an edge, clear out_valid and go to IDLE.
  - result and zero keep their values until the next accept.
  - in_ready=0 in DONE, so there is no accept in the same cycle as the handoff.
- Latency: acceptance edge E0; out_valid is high after edge E0+NBYTES (E4 for WIDTH=32). Throughput is one operation per NBYTES+2 cycles minimum.
- Operand isolation: changes on a, b, op or in_valid while in RUN/DONE are ignored.
- Mid-operation visibility: result may show partial bytes during RUN. Consumers sample only while out_valid=1.
- zero: updates only on the transition to DONE, not during RUN.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-operation (RUN or DONE): return immediately to IDLE. result=0, out_valid=0, the pending operation is dropped, nothing is emitted.
- Illegal WIDTH (not a multiple of 8) is a configuration error. Flag it with an elaboration-time check.

Decomposition:
- Shared constants file (included by ALU blocks): op encodings LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_XOR=2'b10, LOGIC_NOR=2'b11; FSM state encodings.
- Sub-module byte_logic_slice: combinational 8-bit a, b, op -> z. It instantiates the existing 8-bit gate-level XOR for the XOR path and gate-level and/or/nor for the rest.
- FSM, index counter and result register stay in the top module.

Test Plan:
- XOR basic: a=32'hFF00_AA55, b=32'h0F0F_F0F0, op=10 -> result 32'hF00F_5AA5, zero=0, out_valid exactly 4 edges after accept.
- NOR all-ones: a=32'hFFFF_FFFF, b=32'h0000_0000, op=11 -> result 0, zero=1. Then AND a=32'h1234_5678, b=32'h0000_FFFF -> 32'h0000_5678, zero=0.
- Backpressure: op OR, a=32'h8000_0001, b=32'h0000_0100. Hold out_ready=0 for 10 cycles -> out_valid and result 32'h8000_0101 stable, in_ready=0. Release -> IDLE next edge, in_ready=1.
- Operand isolation: after accept of XOR a=32'h0000_0001, b=0, drive a=32'hFFFF_FFFF and in_valid=1 during RUN -> result 32'h0000_0001, no second accept until IDLE.
- Reset mid-RUN: assert rst asynchronously after byte 1 -> out_valid=0, result=0, in_ready=1 after release. A new AND op completes normally.
- Back-to-back: two ops with out_ready tied high -> accepts spaced 6 cycles apart, both results correct in order.
